// File: rtl/mem_stream_sweep.sv
// mem_stream_sweep: memory-to-memory streaming engine.
// Reads numBlocks blocks from srcBase as burst reads into a FIFO, then writes
// them to dstBase as ID-tagged write bursts. Read bursts are throttled by FIFO
// credits, and write bursts are issued only once all of their beats are buffered.
module mem_stream_sweep #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 8,
    parameter int ID_W       = 16,
    parameter int MAX_BURST  = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    input  logic [CNT_W-1:0]  numBlocks,
    output logic [ADDR_W-1:0] inputMemAddr,
    output logic              inputMemAddrValid,
    output logic [LEN_W-1:0]  inputMemAddrLen,
    input  logic              inputMemAddrReady,
    input  logic [DATA_W-1:0] inputMemBlock,
    input  logic              inputMemBlockValid,
    output logic              inputMemBlockReady,
    output logic [ADDR_W-1:0] outputMemAddr,
    output logic              outputMemAddrValid,
    output logic [LEN_W-1:0]  outputMemAddrLen,
    output logic [ID_W-1:0]   outputMemAddrId,
    input  logic              outputMemAddrReady,
    output logic [DATA_W-1:0] outputMemBlock,
    output logic              outputMemBlockValid,
    output logic              outputMemBlockLast,
    input  logic              outputMemBlockReady,
    output logic              finished,
    output logic              busy
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;  // holds 0..FIFO_DEPTH
    localparam int BW  = $clog2(MAX_BURST) + 1;   // holds 0..MAX_BURST
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BSH = $clog2(DATA_W / 8);
    localparam int PW  = 3;                       // pending write bursts 0..4

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]  read_remain, write_remain, data_remain;
    logic [CW-1:0]     count, outstanding, promised;
    logic [CW-1:0]     credits, avail;
    logic [AW-1:0]     wptr, rptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [BW-1:0]     rb, wb, db, beat_idx;
    logic [PW-1:0]     pend_bursts;
    logic              start_ok, run, push, pop, ra_fire, wa_fire, last_beat, final_beat;

    assign run        = (state == RUN);
    assign start_ok   = start && (state != RUN);
    assign push       = inputMemBlockValid && inputMemBlockReady;
    assign pop        = outputMemBlockValid && outputMemBlockReady;
    assign ra_fire    = inputMemAddrValid && inputMemAddrReady;
    assign wa_fire    = outputMemAddrValid && outputMemAddrReady;

    // Beats in the next read burst, next write address burst and current data burst.
    assign rb = (read_remain  > CNT_W'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(read_remain);
    assign wb = (write_remain > CNT_W'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(write_remain);
    assign db = (data_remain  > CNT_W'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(data_remain);

    // Occupancy plus in-flight read beats never exceeds the depth, and promised
    // beats are always already buffered, so neither subtraction underflows.
    assign credits = CW'(FIFO_DEPTH) - count - outstanding;
    assign avail   = count - promised;

    assign outputMemBlock      = mem[rptr];
    assign outputMemBlockValid = (count != '0) && (promised != '0);
    assign last_beat           = (promised != '0) && (beat_idx == db - BW'(1));
    assign outputMemBlockLast  = last_beat;
    assign final_beat          = pop && last_beat && (data_remain == CNT_W'(db));

    // State register and the sticky finished flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            finished <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok)
                finished <= 1'b0;
            else if (run && state_nx == DONE)
                finished <= 1'b1;
        end
    end

    // Next state and state-decoded outputs; a zero-length run leaves RUN after one cycle.
    always_comb begin
        state_nx           = state;
        busy               = 1'b0;
        inputMemBlockReady = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN: begin
                busy               = 1'b1;
                inputMemBlockReady = 1'b1;
                if (final_beat || data_remain == '0) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read request generator; a burst is raised only when the FIFO can hold all its beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_remain       <= '0;
            inputMemAddr      <= '0;
            inputMemAddrLen   <= '0;
            inputMemAddrValid <= 1'b0;
            outstanding       <= '0;
        end else if (start_ok) begin
            read_remain       <= numBlocks;
            inputMemAddr      <= srcBase;
            inputMemAddrLen   <= '0;
            inputMemAddrValid <= 1'b0;
            outstanding       <= '0;
        end else begin
            if (ra_fire) begin
                inputMemAddrValid <= 1'b0;
                inputMemAddr      <= inputMemAddr + (ADDR_W'(rb) << BSH);
                read_remain       <= read_remain - CNT_W'(rb);
            end else if (run && !inputMemAddrValid && read_remain != '0 && credits >= CW'(rb)) begin
                inputMemAddrValid <= 1'b1;
                inputMemAddrLen   <= LEN_W'(rb - BW'(1));
            end
            outstanding <= outstanding + (ra_fire ? CW'(rb) : CW'(0)) - CW'(push);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (start_ok) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage, intentionally not reset.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= inputMemBlock;
    end

    // A push into a full FIFO without a matching pop means the credit scheme is broken.
    always_ff @(posedge clock) begin
        if (reset) assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
    end

    // Write address generator; waits until the whole burst is buffered and at most 4 are pending.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_remain       <= '0;
            outputMemAddr      <= '0;
            outputMemAddrLen   <= '0;
            outputMemAddrId    <= '0;
            outputMemAddrValid <= 1'b0;
        end else if (start_ok) begin
            write_remain       <= numBlocks;
            outputMemAddr      <= dstBase;
            outputMemAddrLen   <= '0;
            outputMemAddrId    <= '0;
            outputMemAddrValid <= 1'b0;
        end else if (wa_fire) begin
            outputMemAddrValid <= 1'b0;
            outputMemAddr      <= outputMemAddr + (ADDR_W'(wb) << BSH);
            write_remain       <= write_remain - CNT_W'(wb);
            outputMemAddrId    <= outputMemAddrId + ID_W'(1);
        end else if (run && !outputMemAddrValid && write_remain != '0 &&
                     pend_bursts < PW'(4) && avail >= CW'(wb)) begin
            outputMemAddrValid <= 1'b1;
            outputMemAddrLen   <= LEN_W'(wb - BW'(1));
        end
    end

    // Write data tracking: beats promised to accepted bursts and position within the current burst.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_remain <= '0;
            beat_idx    <= '0;
            promised    <= '0;
            pend_bursts <= '0;
        end else if (start_ok) begin
            data_remain <= numBlocks;
            beat_idx    <= '0;
            promised    <= '0;
            pend_bursts <= '0;
        end else begin
            promised    <= promised + (wa_fire ? CW'(wb) : CW'(0)) - CW'(pop);
            pend_bursts <= pend_bursts + PW'(wa_fire) - PW'(pop && last_beat);
            if (pop) begin
                if (last_beat) begin
                    beat_idx    <= '0;
                    data_remain <= data_remain - CNT_W'(db);
                end else begin
                    beat_idx <= beat_idx + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stream_sweep.sv
// Bench for mem_stream_sweep: memory models on both sides, a transaction-level
// reference (expected burst list, data stream and IDs), table-driven transfers
// and hand-written sequences for zero-length, reset and restart corners.
module tb_mem_stream_sweep;
    localparam int DW = 512, AW = 64, LW = 8, IW = 2, MB = 64, FD = 128, CW = 32;
    localparam int BYTES = DW / 8;
    localparam int STALL = 600;

    logic          clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] srcBase = '0, dstBase = '0;
    logic [CW-1:0] numBlocks = '0;
    logic [AW-1:0] inputMemAddr, outputMemAddr;
    logic          inputMemAddrValid, outputMemAddrValid, outputMemBlockValid, outputMemBlockLast;
    logic [LW-1:0] inputMemAddrLen, outputMemAddrLen;
    logic [IW-1:0] outputMemAddrId;
    logic          inputMemAddrReady = 1'b0, inputMemBlockValid = 1'b0, inputMemBlockReady;
    logic          outputMemAddrReady = 1'b0, outputMemBlockReady = 1'b0;
    logic [DW-1:0] inputMemBlock = '0, outputMemBlock;
    logic          finished, busy;

    always #5 clock = ~clock;

    mem_stream_sweep #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .ID_W(IW), .MAX_BURST(MB),
                       .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .srcBase(srcBase), .dstBase(dstBase), .numBlocks(numBlocks),
        .inputMemAddr(inputMemAddr), .inputMemAddrValid(inputMemAddrValid),
        .inputMemAddrLen(inputMemAddrLen), .inputMemAddrReady(inputMemAddrReady),
        .inputMemBlock(inputMemBlock), .inputMemBlockValid(inputMemBlockValid),
        .inputMemBlockReady(inputMemBlockReady),
        .outputMemAddr(outputMemAddr), .outputMemAddrValid(outputMemAddrValid),
        .outputMemAddrLen(outputMemAddrLen), .outputMemAddrId(outputMemAddrId),
        .outputMemAddrReady(outputMemAddrReady),
        .outputMemBlock(outputMemBlock), .outputMemBlockValid(outputMemBlockValid),
        .outputMemBlockLast(outputMemBlockLast), .outputMemBlockReady(outputMemBlockReady),
        .finished(finished), .busy(busy)
    );

    // mode: 0 all ready, 1 random backpressure and read gaps, 2 write address held off
    typedef struct {
        int          num;
        logic [63:0] src;
        logic [63:0] dst;
        int          mode;
        int          inject;
        int          abort_at;
        int          exp_rd;
        int          exp_last;
    } xfer_t;

    int checks = 0, failures = 0;

    // reference model state
    int          m_num, m_rd_rem, m_wr_rem, m_id, m_rd_cnt, m_req_beats, m_wbeats;
    int          m_last_cnt, m_bidx, mode, cyc, fin_rise;
    logic [63:0] m_rd_addr, m_wr_addr, m_src;
    logic [31:0] seed;
    logic [63:0] beat_q[$];
    int          m_blen_q[$];
    logic        fin_next, fin_prev;
    logic        ra_hold, wa_hold, wd_hold;
    logic [63:0] ra_addr_s, wa_addr_s;
    logic [LW-1:0] ra_len_s, wa_len_s;
    logic [IW-1:0] wa_id_s;
    logic [DW-1:0] wd_data_s;
    logic          wd_last_s;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [63:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++)
            r[k*32 +: 32] = a[37:6] ^ a[63:32] ^ (seed * 32'(k + 1));
        return r;
    endfunction

    function automatic int min_b(input int rem);
        return (rem > MB) ? MB : rem;
    endfunction

    task automatic rst_checks(input string tag);
        chk({tag, "_arvalid"}, inputMemAddrValid, 0);
        chk({tag, "_awvalid"}, outputMemAddrValid, 0);
        chk({tag, "_wvalid"}, outputMemBlockValid, 0);
        chk({tag, "_wlast"}, outputMemBlockLast, 0);
        chk({tag, "_rready"}, inputMemBlockReady, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_araddr"}, inputMemAddr, 0);
        chk({tag, "_arlen"}, inputMemAddrLen, 0);
        chk({tag, "_awaddr"}, outputMemAddr, 0);
        chk({tag, "_awlen"}, outputMemAddrLen, 0);
        chk({tag, "_awid"}, outputMemAddrId, 0);
    endtask

    // One clock: evaluate the handshakes of the coming edge at negedge, then drive after it.
    task automatic step();
        logic ra_f, rd_f, wa_f, wd_f, is_last;
        int   b;
        @(negedge clock);
        ra_f = inputMemAddrValid && inputMemAddrReady;
        rd_f = inputMemBlockValid && inputMemBlockReady;
        wa_f = outputMemAddrValid && outputMemAddrReady;
        wd_f = outputMemBlockValid && outputMemBlockReady;
        if (ra_hold) chk("ra_stable", {inputMemAddrValid, inputMemAddrLen, inputMemAddr},
                         {1'b1, ra_len_s, ra_addr_s});
        if (wa_hold) chk("wa_stable", {outputMemAddrValid, outputMemAddrId, outputMemAddrLen, outputMemAddr},
                         {1'b1, wa_id_s, wa_len_s, wa_addr_s});
        if (wd_hold) begin
            chk("wd_stable_ctl", {outputMemBlockValid, outputMemBlockLast}, {1'b1, wd_last_s});
            chk("wd_stable_data", outputMemBlock, wd_data_s);
        end
        if (fin_next) begin
            chk("fin_timing", finished, 1);
            fin_next = 1'b0;
        end
        if (finished && !fin_prev) fin_rise++;
        fin_prev = finished;

        if (wd_f) begin
            chk("wd_has_addr", m_blen_q.size() > 0, 1);
            chk("wd_data", outputMemBlock, pat(m_src + 64'(m_wbeats * BYTES)));
            if (m_blen_q.size() > 0) begin
                is_last = (m_bidx == m_blen_q[0] - 1);
                chk("wd_last", outputMemBlockLast, is_last);
                if (is_last) begin
                    void'(m_blen_q.pop_front());
                    m_bidx = 0;
                    m_last_cnt++;
                end else m_bidx++;
            end
            m_wbeats++;
            if (m_wbeats == m_num) fin_next = 1'b1;
        end
        if (wa_f) begin
            b = min_b(m_wr_rem);
            chk("wr_req_expected", m_wr_rem > 0, 1);
            chk("wr_addr", outputMemAddr, m_wr_addr);
            chk("wr_len", outputMemAddrLen, b - 1);
            chk("wr_id", outputMemAddrId, m_id % 4);
            m_blen_q.push_back(b);
            chk("wr_pending_limit", m_blen_q.size() <= 4, 1);
            m_wr_addr += 64'(b * BYTES);
            m_wr_rem  -= b;
            m_id++;
        end
        if (ra_f) begin
            b = min_b(m_rd_rem);
            chk("rd_req_expected", m_rd_rem > 0, 1);
            chk("rd_addr", inputMemAddr, m_rd_addr);
            chk("rd_len", inputMemAddrLen, b - 1);
            m_req_beats += b;
            chk("rd_credit", (m_req_beats - m_wbeats) <= FD, 1);
            for (int i = 0; i < b; i++) beat_q.push_back(inputMemAddr + 64'(i * BYTES));
            m_rd_addr += 64'(b * BYTES);
            m_rd_rem  -= b;
            m_rd_cnt++;
        end
        if (rd_f && beat_q.size() > 0) void'(beat_q.pop_front());

        ra_hold = inputMemAddrValid && !inputMemAddrReady;
        ra_addr_s = inputMemAddr;  ra_len_s = inputMemAddrLen;
        wa_hold = outputMemAddrValid && !outputMemAddrReady;
        wa_addr_s = outputMemAddr; wa_len_s = outputMemAddrLen; wa_id_s = outputMemAddrId;
        wd_hold = outputMemBlockValid && !outputMemBlockReady;
        wd_data_s = outputMemBlock; wd_last_s = outputMemBlockLast;

        @(posedge clock);
        #1;
        cyc++;
        if (rd_f) inputMemBlockValid = 1'b0;
        if (!inputMemBlockValid && beat_q.size() > 0 && (mode != 1 || $urandom_range(0, 2) != 0)) begin
            inputMemBlockValid = 1'b1;
            inputMemBlock      = pat(beat_q[0]);
        end
        case (mode)
            1: begin
                inputMemAddrReady   = ($urandom_range(0, 3) != 0);
                outputMemAddrReady  = ($urandom_range(0, 3) != 0);
                outputMemBlockReady = ($urandom_range(0, 3) != 0);
            end
            2: begin
                inputMemAddrReady   = 1'b1;
                outputMemAddrReady  = (cyc >= STALL);
                outputMemBlockReady = 1'b1;
            end
            default: begin
                inputMemAddrReady   = 1'b1;
                outputMemAddrReady  = 1'b1;
                outputMemBlockReady = 1'b1;
            end
        endcase
    endtask

    task automatic run_xfer(input xfer_t t);
        logic done;
        m_num = t.num; m_rd_rem = t.num; m_wr_rem = t.num;
        m_rd_addr = t.src; m_wr_addr = t.dst; m_src = t.src;
        m_id = 0; m_rd_cnt = 0; m_req_beats = 0; m_wbeats = 0; m_last_cnt = 0; m_bidx = 0;
        beat_q.delete(); m_blen_q.delete();
        ra_hold = 0; wa_hold = 0; wd_hold = 0; fin_next = 0; fin_rise = 0;
        fin_prev = finished; mode = t.mode; cyc = 0; seed = $urandom;
        inputMemBlockValid = 1'b0;
        srcBase = t.src; dstBase = t.dst; numBlocks = CW'(t.num); start = 1'b1;
        step();
        start = 1'b0;
        srcBase = {$urandom, $urandom}; dstBase = {$urandom, $urandom};
        numBlocks = CW'($urandom_range(1, 50));
        chk("fin_clear", finished, 0);
        chk("busy_run", busy, 1);
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            if (t.inject > 0 && cyc == t.inject) begin
                start = 1'b1;
                numBlocks = CW'(7);
            end else start = 1'b0;
            if (t.mode == 2 && cyc == STALL - 1) begin
                chk("stall_rd_count", m_rd_cnt, 2);
                chk("stall_arvalid", inputMemAddrValid, 0);
            end
            if (t.abort_at > 0 && cyc == t.abort_at) return;
            step();
            if (m_wbeats == t.num && finished) done = 1'b1;
        end
        start = 1'b0;
        chk("timeout", done, 1);
        repeat (4) step();
        chk("fin_once", fin_rise, 1);
        chk("fin_sticky", finished, 1);
        chk("busy_done", busy, 0);
        chk("rd_burst_count", m_rd_cnt, t.exp_rd);
        chk("last_count", m_last_cnt, t.exp_last);
        chk("beats_written", m_wbeats, t.num);
        chk("idle_valids", {inputMemAddrValid, outputMemAddrValid, outputMemBlockValid}, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        xfer_t tbl[5];
        xfer_t t;
        logic  zero_valid;
        tbl[0] = '{200,  64'h0000_0000_1000_0000, 64'h0000_0000_2000_0000, 0, 0,  0, 4,  4};
        tbl[1] = '{200,  64'h0000_0000_3000_0000, 64'h0000_0000_4000_0040, 2, 0,  0, 4,  4};
        tbl[2] = '{1000, 64'h0000_0012_0000_0000, 64'h0000_0034_0000_0000, 1, 0,  0, 16, 16};
        tbl[3] = '{384,  64'h0000_0000_5000_0000, 64'h0000_0000_6000_0000, 0, 40, 0, 6,  6};
        tbl[4] = '{200,  64'hFFFF_FFFF_FFFF_E000, 64'hFFFF_FFFF_FFFF_F000, 1, 0,  0, 4,  4};

        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rst_checks("rst");
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

        // zero-length run: finished drops after start, returns one edge later, nothing issued
        numBlocks = '0; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("zero_fin_clear", finished, 0);
        zero_valid = inputMemAddrValid | outputMemAddrValid | outputMemBlockValid;
        @(posedge clock);
        #1;
        chk("zero_fin_set", finished, 1);
        chk("zero_busy", busy, 0);
        repeat (5) begin
            zero_valid |= inputMemAddrValid | outputMemAddrValid | outputMemBlockValid;
            @(posedge clock);
            #1;
        end
        chk("zero_no_valid", zero_valid, 0);

        // abandon a transfer with an asynchronous reset, then run a short one
        t = '{1000, 64'h0000_0000_7000_0000, 64'h0000_0000_8000_0000, 1, 0, 300, 0, 0};
        run_xfer(t);
        #2 reset = 1'b0;
        #1;
        rst_checks("async_rst");
        beat_q.delete();
        inputMemBlockValid = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        t = '{5, 64'h0000_0000_9000_0000, 64'h0000_0000_A000_0000, 0, 0, 0, 1, 1};
        run_xfer(t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
